// File: rtl/fifo_sram_pkg.sv
// Shared definitions for the FIFO-SRAM packet buffer processor-port logic.
// - Default widths of the buffer port (data, address).
// - Register-window select bit and register offsets inside that window.
// - Arbiter state encoding and the debug record the arbiter exposes.
package fifo_sram_pkg;

  localparam int DEF_DWIDTH  = 72;
  localparam int DEF_AWIDTH  = 10;

  // addra[REG_SEL_BIT]=1 steers the access to the control-register window.
  localparam int REG_SEL_BIT = 9;

  // Register offsets inside the window.
  localparam logic [7:0] REG_STATUS  = 8'h00;
  localparam logic [7:0] REG_SOP_PTR = 8'h01;
  localparam logic [7:0] REG_EOP_PTR = 8'h02;
  localparam logic [7:0] REG_DROP    = 8'h03;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Snapshot of the arbiter's internal state for checkers and debug.
  // Pointer/owner fields are sized for the largest supported NREQ (4).
  typedef struct packed {
    arb_state_e  state;
    logic [1:0]  rr_ptr;
    logic [1:0]  owner;
    logic [7:0]  burst_cnt;
    logic        reg_access;
  } arb_dbg_t;

endpackage

// File: rtl/fifo_sram_port_arbiter_if.sv
// Bundle of the requester-side handshake, the buffer port and the arbiter
// debug record.
//   req_valid/req_we/req_lock  per-requester request, direction, burst lock
//   req_addr/req_wdata         packed per-requester address and write data
//   req_ready                  access accepted this cycle
//   rsp_valid/rsp_rdata        one-hot read response and shared read data
//   port_hold                  stall from the packet controller
//   wea/addra/dina/douta       buffer processor port
//   dbg                        arbiter state snapshot
// Modports: slave = arbiter side, master = requesters plus buffer side.
//
// Handshake: a requester raises req_valid with stable we/lock/addr/wdata and
// keeps them stable until it sees req_ready=1 in the same cycle; that cycle
// is the accept and the request may change afterwards. req_ready never
// depends on anything but the current-cycle inputs and arbiter state.
interface fifo_sram_port_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int DWIDTH = 72,
  parameter int AWIDTH = 10
) ();
  import fifo_sram_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_we;
  logic [NREQ-1:0]        req_lock;
  logic [NREQ*AWIDTH-1:0] req_addr;
  logic [NREQ*DWIDTH-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DWIDTH-1:0]      rsp_rdata;
  logic                   port_hold;
  logic                   wea;
  logic [AWIDTH-1:0]      addra;
  logic [DWIDTH-1:0]      dina;
  logic [DWIDTH-1:0]      douta;
  arb_dbg_t               dbg;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, port_hold, douta,
    output req_ready, rsp_valid, rsp_rdata, wea, addra, dina, dbg
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, port_hold, douta,
    input  req_ready, rsp_valid, rsp_rdata, wea, addra, dina, dbg
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: rotate the request vector to start at ptr and pick the
// first set bit, wrapping modulo N. Purely combinational.
//   req    N-bit request vector
//   ptr    index searched first
//   grant  one-hot grant (all zero when no request)
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int PW = $clog2(N);

  logic [PW:0] idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      // One extra bit keeps ptr+k from overflowing before the modulo fold.
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) begin
        idx = idx - (PW+1)'(N);
      end
      if (!found && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_sram_port_arbiter.sv
// Shares the single processor port of the FIFO-SRAM packet buffer (and its
// register window) between NREQ requesters.
//   clk, reset  clock, asynchronous active-high reset
//   bus         fifo_sram_port_arbiter_if.slave: requester handshake,
//               buffer port (wea/addra/dina registered, douta 1 cycle
//               after addra), controller stall, debug snapshot
// Round-robin arbitration with an optional burst lock bounded by MAX_BURST
// accepts. Read responses return three cycles after the accept, in order,
// routed through a two-stage {rd, id} tag pipeline.
module fifo_sram_port_arbiter
  import fifo_sram_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter int NREQ      = 2,
  parameter int MAX_BURST = 4
) (
  input logic                     clk,
  input logic                     reset,
  fifo_sram_port_arbiter_if.slave bus
);

  localparam int              IDW        = $clog2(NREQ);
  localparam int              BCW        = $clog2(MAX_BURST + 1);
  localparam logic [IDW-1:0]  LAST_ID    = IDW'(NREQ - 1);
  localparam logic [BCW-1:0]  BURST_LAST = BCW'(MAX_BURST - 1);
  localparam bit              LOCK_EN    = (MAX_BURST > 1);

  arb_state_e        state_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [IDW-1:0]    owner_q;
  logic [BCW-1:0]    burst_cnt_q;

  logic [NREQ-1:0]   arb_grant;
  logic [NREQ-1:0]   owner_grant;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ready;
  logic              accept;
  logic [IDW-1:0]    acc_id;
  logic [IDW-1:0]    next_ptr;
  logic              acc_we;
  logic              acc_lock;
  logic [AWIDTH-1:0] acc_addr;
  logic [DWIDTH-1:0] acc_wdata;

  logic              tag1_rd;
  logic [IDW-1:0]    tag1_id;
  logic              tag2_rd;
  logic [IDW-1:0]    tag2_id;
  logic [NREQ-1:0]   rsp_onehot;

  rr_arbiter #(.N(NREQ)) u_rr_arbiter (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant)
  );

  always_comb begin
    owner_grant          = '0;
    owner_grant[owner_q] = 1'b1;
  end

  // While locked the owner keeps the port even when idle.
  assign grant = (state_q == LOCKED) ? owner_grant : arb_grant;

  // Held low during reset so nothing is handed out before state is defined.
  assign ready         = reset ? '0 : (grant & bus.req_valid & {NREQ{~bus.port_hold}});
  assign bus.req_ready = ready;
  assign accept        = |ready;

  always_comb begin
    acc_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ready[i]) begin
        acc_id = IDW'(i);
      end
    end
  end

  assign acc_we    = bus.req_we[acc_id];
  assign acc_lock  = bus.req_lock[acc_id];
  assign acc_addr  = bus.req_addr[int'(acc_id)*AWIDTH +: AWIDTH];
  assign acc_wdata = bus.req_wdata[int'(acc_id)*DWIDTH +: DWIDTH];
  assign next_ptr  = (acc_id == LAST_ID) ? '0 : acc_id + 1'b1;

  // Arbitration FSM. Nothing moves without an accept, so port_hold freezes
  // state, pointer and burst count for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else if (accept) begin
      case (state_q)
        ARB: begin
          if (acc_lock && LOCK_EN) begin
            state_q     <= LOCKED;
            owner_q     <= acc_id;
            burst_cnt_q <= BCW'(1);
          end else begin
            rr_ptr_q <= next_ptr;
          end
        end
        LOCKED: begin
          // Only the owner can be accepted here, so next_ptr is owner+1.
          if (!acc_lock || (burst_cnt_q == BURST_LAST)) begin
            state_q     <= ARB;
            rr_ptr_q    <= next_ptr;
            burst_cnt_q <= '0;
          end else begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  // Registered buffer port drive; address/data hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.wea   <= 1'b0;
      bus.addra <= '0;
      bus.dina  <= '0;
    end else begin
      bus.wea <= accept & acc_we;
      if (accept) begin
        bus.addra <= acc_addr;
        bus.dina  <= acc_wdata;
      end
    end
  end

  // Tag stage 1 lines up with addra, stage 2 with douta.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag1_rd <= 1'b0;
      tag1_id <= '0;
      tag2_rd <= 1'b0;
      tag2_id <= '0;
    end else begin
      tag1_rd <= accept & ~acc_we;
      tag1_id <= acc_id;
      tag2_rd <= tag1_rd;
      tag2_id <= tag1_id;
    end
  end

  always_comb begin
    rsp_onehot          = '0;
    rsp_onehot[tag2_id] = tag2_rd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= rsp_onehot;
      if (tag2_rd) begin
        bus.rsp_rdata <= bus.douta;
      end
    end
  end

  assign bus.dbg = '{
    state:      state_q,
    rr_ptr:     2'(rr_ptr_q),
    owner:      2'(owner_q),
    burst_cnt:  8'(burst_cnt_q),
    reg_access: bus.addra[REG_SEL_BIT]
  };

endmodule

// File: doc/fifo_sram_port_arbiter.md
Name: fifo_sram_port_arbiter

Overview:
- Shares the single processor-side port of the FIFO-SRAM packet buffer and its control-register window (wea/addra/dina/douta, addra[9]=1 selects registers) between NREQ requesters, e.g. RISC-V core data port and HW accelerator.
- Round-robin arbitration with optional bounded burst lock, so a read-modify-write or a descriptor fetch completes atomically.
- Registered port drive, in-order read-response routing, hold input from the packet controller's stall.

Parameters:
- DWIDTH, 72, data width of the buffer port.
- AWIDTH, 10, port address width; bit 9 selects the register window.
- NREQ, 2, number of requesters (2..4).
- MAX_BURST, 4, maximum consecutive accepts under lock before forced release (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester access request.
- req_we  in  NREQ  1=write, 0=read.
- req_lock  in  NREQ  keep grant after this access (burst/RMW).
- req_addr  in  NREQ*AWIDTH  packed addresses, requester i at [i*AWIDTH +: AWIDTH].
- req_wdata  in  NREQ*DWIDTH  packed write data.
- req_ready  out  NREQ  access accepted this cycle (combinational).
- rsp_valid  out  NREQ  read data valid for requester i (one-hot).
- rsp_rdata  out  DWIDTH  read data, shared by all requesters.
- port_hold  in  1  blocks new accepts (controller stall).
- wea  out  1  buffer write enable (registered).
- addra  out  AWIDTH  buffer address (registered).
- dina  out  DWIDTH  buffer write data (registered).
- douta  in  DWIDTH  buffer read data, valid 1 cycle after addra.

Behaviour:
- Reset values: wea=0, addra=0, dina=0, rsp_valid=0, rsp_rdata=0, rr_ptr=0, state=ARB, burst_cnt=0, owner=0, read pipeline cleared. req_ready is combinational and 0 while reset is asserted.
- Accept condition: req_ready[i]=1 only when i is granted, req_valid[i]=1 and port_hold=0. At most one bit of req_ready is high per cycle.
- Port drive on an accept in cycle T:
  - wea, addra, dina take the requester's values at T+1.
  - With no accept, wea=0 at T+1; addra and dina hold their previous values.
- Read latency: for a read accepted at T, douta is valid at T+2. rsp_rdata is registered from douta, so rsp_valid[i] and rsp_rdata appear at T+3.
- Read responses: two-stage tag pipeline {rd, id} preserves order. Writes produce no response. Back-to-back accepts give one access per cycle with no bubbles.
- State ARB:
  - Grant goes to the first i with req_valid set, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - On accept:
    - If req_lock[i]=1 and MAX_BURST>1: owner=i, burst_cnt=1, go to LOCKED. rr_ptr is unchanged.
    - Otherwise rr_ptr = i+1 mod NREQ.
- State LOCKED:
  - Only the owner is granted; other requesters wait even if the owner is idle.
  - Owner accept with req_lock=0: go to ARB, rr_ptr = owner+1.
  - Owner accept with req_lock=1: burst_cnt increments. If it reaches MAX_BURST, forced release: go to ARB, rr_ptr = owner+1.
  - Owner deasserts req_valid while locked: it stays LOCKED. A requester must not leave a lock pending indefinitely; the bench checks liveness only under compliant stimulus.
- port_hold=1: no accepts and no state or pointer change. In-flight reads still complete and return responses.
- MAX_BURST=1: lock is ignored and the block stays in ARB.
- Asynchronous reset mid-operation: in-flight reads are discarded and no rsp_valid is produced for them. Any buffer write already driven on wea has completed.
- Requester IDs are clog2(NREQ) bits wide. rr_ptr wraps modulo NREQ (NREQ=3 wraps 2->0).

Decomposition:
- Shared package fifo_sram_pkg: arbiter states {ARB, LOCKED}, REG_SEL_BIT=9, register offsets (0x00 status, 0x01 SOP pointer, 0x02 EOP pointer, 0x03 drop flag), default DWIDTH/AWIDTH.
- One sub-module: rr_arbiter (request vector, pointer -> one-hot grant). Rotate-and-priority-encode, purely combinational, reusable elsewhere.

Test Plan:
- Reset, then req_valid=2'b11, both reads, lock=0, held 4 cycles -> req_ready alternates 01,10,01,10; addra follows one cycle later; rsp_valid one-hot alternating from cycle 3 with matching data.
- Requester 0 sends 6 accesses with lock=1, requester 1 pending, MAX_BURST=4 -> four req_ready[0] in a row, then requester 1 granted, then requester 0 resumes.
- Read of addr 0x200 (reg 0) holding 0x...F, immediately followed by write 0x200 <= 0 from requester 1 -> wea=1 at T+2; requester 0 gets rsp_rdata=0x...F at T+3.
- port_hold=1 for 3 cycles with a read in flight -> req_ready=0 and wea=0 while held; in-flight rsp_valid still fires; arbitration resumes with unchanged rr_ptr.
- Reset asserted the cycle after a read is accepted -> wea, addra and rsp_valid go 0 immediately; no response after reset release.
- NREQ=3, only requesters 0 and 2 active -> grants alternate 0,2,0,2 with the pointer wrapping correctly.
